// File: rtl/counter_sequencer.sv
// Run-control sequencer for a WIDTH-bit up-counter with a programmable prescaler.
// Handles start/hold/stop, terminal-count detection, and one-shot vs auto-reload.
module counter_sequencer #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               auto_reload,
    input  logic [WIDTH-1:0]   term_val,
    input  logic [PRESC_W-1:0] prescale,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t             st;
    logic [PRESC_W-1:0] pre_cnt;
    logic [PRESC_W-1:0] pre_q;
    logic [WIDTH-1:0]   term_q;
    logic               active;

    assign active = (st == RUN) || (st == HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st      <= IDLE;
            count   <= '0;
            pre_cnt <= '0;
            pre_q   <= '0;
            term_q  <= '0;
            tc      <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (stop && st != IDLE) begin
                st      <= IDLE;
                count   <= '0;
                pre_cnt <= '0;
            end else if (start) begin
                st      <= RUN;
                count   <= '0;
                pre_cnt <= '0;
                term_q  <= term_val;
                pre_q   <= prescale;
            end else if (active && hold) begin
                st <= HOLD;
            end else if (active) begin
                // The release edge out of HOLD is an ordinary run edge, so a
                // hold of N edges delays the sequence by exactly N cycles.
                st <= RUN;
                if (pre_cnt == pre_q) begin
                    pre_cnt <= '0;
                    if (count != term_q) begin
                        count <= count + 1'b1;
                    end else begin
                        tc <= 1'b1;
                        if (auto_reload) count <= '0;
                        else             st    <= DONE;
                    end
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end
        end
    end

    assign state = st;
    assign busy  = active;
    assign done  = (st == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random stimulus, all
// checked every cycle against an elapsed-cycle arithmetic model.
module tb_counter_sequencer;

    localparam int WIDTH   = 4;
    localparam int PRESC_W = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start, stop, hold, auto_reload;
    logic [WIDTH-1:0]   term_val;
    logic [PRESC_W-1:0] prescale;
    logic [WIDTH-1:0]   count;
    logic               tc, busy, done;
    logic [1:0]         state;

    int vectors     = 0;
    int miscompares = 0;

    // Model: mode 0 idle, 1 run, 2 hold, 3 done; elapsed = un-held run edges since start
    int m_mode, m_elapsed, m_term, m_pre, m_count, m_tc;

    counter_sequencer #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .hold(hold),
        .auto_reload(auto_reload), .term_val(term_val), .prescale(prescale),
        .count(count), .tc(tc), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0; m_term = 0; m_pre = 0; m_count = 0; m_tc = 0;
    endtask

    task automatic model_edge();
        int k;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_tc = 0;
        if (stop && m_mode != 0) begin
            m_mode = 0; m_count = 0;
        end else if (start) begin
            m_mode = 1; m_elapsed = 0; m_count = 0;
            m_term = int'(term_val); m_pre = int'(prescale);
        end else if ((m_mode == 1 || m_mode == 2) && hold) begin
            m_mode = 2;
        end else if (m_mode == 1 || m_mode == 2) begin
            m_mode = 1;
            m_elapsed++;
            if (m_elapsed % (m_pre + 1) == 0) begin
                k = m_elapsed / (m_pre + 1);
                if (k % (m_term + 1) == 0) begin
                    m_tc = 1;
                    if (auto_reload) m_count = 0;
                    else begin m_mode = 3; m_count = m_term; end
                end else begin
                    m_count = k % (m_term + 1);
                end
            end
        end
    endtask

    task automatic cmp_model();
        chk("count", 32'(count), m_count);
        chk("tc",    32'(tc),    m_tc);
        chk("busy",  32'(busy),  (m_mode == 1 || m_mode == 2) ? 1 : 0);
        chk("done",  32'(done),  (m_mode == 3) ? 1 : 0);
        chk("state", 32'(state), m_mode);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; hold = 0;
    endtask

    task automatic do_start(input int tv, input int ps, input logic ar);
        term_val = WIDTH'(tv); prescale = PRESC_W'(ps); auto_reload = ar;
        start = 1; step(); start = 0;
    endtask

    initial begin
        int n_tc, first_tc, steps;
        reset_n = 0; idle_inputs(); auto_reload = 0; term_val = '0; prescale = '0;
        model_reset();
        #2 chk("reset_state", 32'(state), 0);
        chk("reset_count", 32'(count), 0);
        step(); step();
        reset_n = 1;
        step();

        // 1: one-shot, term 3, prescale 0
        do_start(3, 0, 0);
        chk("t1_count0", 32'(count), 0);
        chk("t1_run", 32'(state), 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t1_count", 32'(count), i);
        end
        step();
        chk("t1_done_state", 32'(state), 3);
        chk("t1_done", 32'(done), 1);
        chk("t1_tc", 32'(tc), 1);
        chk("t1_hold3", 32'(count), 3);
        step();
        chk("t1_tc_off", 32'(tc), 0);
        chk("t1_still3", 32'(count), 3);

        // 2: auto-reload, term 9, prescale 2 -> tc every 30 clocks
        do_start(9, 2, 1);
        n_tc = 0; first_tc = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (tc) begin n_tc++; if (first_tc < 0) first_tc = i; end
            if (i == 3) chk("t2_step3", 32'(count), 1);
            if (i == 30) chk("t2_wrap", 32'(count), 0);
        end
        chk("t2_tc_count", n_tc, 2);
        chk("t2_first_tc", first_tc, 30);
        chk("t2_busy", 32'(busy), 1);

        // 3: hold at count 5 one cycle into the prescale period
        do_start(9, 3, 0);
        steps = 0;
        while (count != 4'd5 && steps < 100) begin step(); steps++; end
        chk("t3_reach5", 32'(count), 5);
        step();
        hold = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_state", 32'(state), 2);
            chk("t3_frozen", 32'(count), 5);
        end
        hold = 0;
        step(); step();
        chk("t3_not_yet", 32'(count), 5);
        step();
        chk("t3_resumed", 32'(count), 6);

        // 4: start+stop same edge; term_val change after start ignored
        do_start(3, 1, 0);
        step();
        start = 1; stop = 1; step(); idle_inputs();
        chk("t4_idle", 32'(state), 0);
        chk("t4_busy", 32'(busy), 0);
        do_start(3, 0, 0);
        term_val = 4'd7;
        for (int i = 0; i < 10; i++) step();
        chk("t4_end3", 32'(count), 3);
        chk("t4_done", 32'(done), 1);

        // 5: asynchronous reset mid-cycle at count 6
        do_start(9, 0, 0);
        for (int i = 0; i < 6; i++) step();
        chk("t5_count6", 32'(count), 6);
        #2 reset_n = 0;
        #1 model_reset();
        chk("t5_async_count", 32'(count), 0);
        chk("t5_async_state", 32'(state), 0);
        chk("t5_async_tc", 32'(tc), 0);
        @(negedge clk);
        reset_n = 1;
        step();
        chk("t5_idle", 32'(state), 0);

        // 6: term 0, prescale 0, auto-reload -> tc every cycle
        do_start(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_tc", 32'(tc), 1);
            chk("t6_count", 32'(count), 0);
        end
        auto_reload = 0;
        step();
        chk("t6_done", 32'(state), 3);
        do_start(0, 0, 0);
        chk("t6_restart", 32'(state), 1);

        // Random stimulus
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 24) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            auto_reload = $urandom_range(0, 3) != 0;
            term_val = WIDTH'($urandom_range(0, 5));
            prescale = PRESC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 0;
                #1 model_reset();
                chk("rnd_async", 32'(state), 0);
                @(negedge clk);
                reset_n = 1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
